// File: rtl/ccd_frame_capture.sv
// Sensor timing to pixel stream front end: start/stop control, frame counter, line-length error flags.
// Optional border crop is enabled with `define CCD_BORDER_CROP_EN.
`timescale 1ns/1ps
module ccd_frame_capture #(
  parameter int unsigned num_rows          = 32,
  parameter int unsigned num_cols          = 32,
  parameter int unsigned full_frame_rows   = 36,
  parameter int unsigned full_frame_cols   = 36,
  parameter int unsigned num_bits_rgb      = 12,
  parameter int unsigned frame_count_width = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         ccd_fval,
  input  logic                         ccd_lval,
  input  logic [num_bits_rgb-1:0]      ccd_r,
  input  logic [num_bits_rgb-1:0]      ccd_g,
  input  logic [num_bits_rgb-1:0]      ccd_b,
  output logic [num_bits_rgb-1:0]      red_out,
  output logic [num_bits_rgb-1:0]      green_out,
  output logic [num_bits_rgb-1:0]      blue_out,
  output logic [$clog2(num_rows)-1:0]  x_pos,
  output logic [$clog2(num_cols)-1:0]  y_pos,
  output logic                         d_val,
  output logic                         f_val,
  output logic [frame_count_width-1:0] frame_count,
  output logic                         err_short,
  output logic                         err_long,
  output logic                         busy
);

  localparam int unsigned XW = $clog2(num_rows);
  localparam int unsigned YW = $clog2(num_cols);
  localparam int unsigned MAX_ROWS = (full_frame_rows > num_rows) ? full_frame_rows : num_rows;
  localparam int unsigned MAX_COLS = (full_frame_cols > num_cols) ? full_frame_cols : num_cols;
  localparam int unsigned RW = $clog2(MAX_ROWS + 1);
  localparam int unsigned CW = $clog2(MAX_COLS + 2) + 1;
  localparam int unsigned FW = frame_count_width;

`ifdef CCD_BORDER_CROP_EN
  localparam int unsigned BX        = (full_frame_cols - num_cols) / 2;
  localparam int unsigned BY        = (full_frame_rows - num_rows) / 2;
  localparam int unsigned RAW_ROWS  = full_frame_rows;
  localparam int unsigned SHORT_LIM = BX + num_cols;
  localparam int unsigned LONG_LIM  = full_frame_cols;
`else
  localparam int unsigned BX        = 0;
  localparam int unsigned BY        = 0;
  localparam int unsigned RAW_ROWS  = num_rows;
  localparam int unsigned SHORT_LIM = num_cols;
  localparam int unsigned LONG_LIM  = num_cols;
`endif

  localparam logic [RW-1:0] BY_R    = RW'(BY);
  localparam logic [RW-1:0] ROWS_R  = RW'(RAW_ROWS);
  localparam logic [CW-1:0] BX_C    = CW'(BX);
  localparam logic [CW-1:0] SHORT_C = CW'(SHORT_LIM);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_LIM);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ACTIVE = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic                    fval_prev_q, lval_prev_q;
  logic                    stop_pend_q, stop_pend_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [num_bits_rgb-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic                    d_val_q, d_val_d, f_val_q, f_val_d;
  logic [FW-1:0]           fc_q, fc_d;
  logic                    err_short_q, err_short_d, err_long_q, err_long_d;
  logic                    busy_q, busy_d;

  logic          fval_rise, fval_fall, lval_rise, lval_fall;
  logic          pix_in, active, in_rows, line_end, row_win, col_win, pix_valid;
  logic [CW-1:0] col_now;

  assign fval_rise = ccd_fval & ~fval_prev_q;
  assign fval_fall = ~ccd_fval & fval_prev_q;
  assign lval_rise = ccd_lval & ~lval_prev_q;
  assign lval_fall = ~ccd_lval & lval_prev_q;
  assign pix_in    = ccd_fval & ccd_lval;
  assign active    = (state_q == ACTIVE);
  assign col_now   = lval_rise ? '0 : col_q;
  assign in_rows   = (row_q < ROWS_R);
  // A line also ends when the frame drops while the line is still open
  assign line_end  = active & (lval_fall | (fval_fall & lval_prev_q));

`ifdef CCD_BORDER_CROP_EN
  assign row_win = (row_q >= BY_R) && (row_q < RW'(BY + num_rows));
  assign col_win = (col_now >= BX_C) && (col_now < SHORT_C);
`else
  assign row_win = in_rows;
  assign col_win = (col_now < SHORT_C);
`endif
  assign pix_valid = active & pix_in & row_win & col_win;

  // Next-state, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    col_d       = col_q;
    row_d       = row_q;
    fc_d        = fc_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    x_d         = x_q;
    y_d         = y_q;
    d_val_d     = 1'b0;
    f_val_d     = 1'b0;
    busy_d      = 1'b0;

    if (lval_rise) col_d = '0;
    if (pix_in)    col_d = (col_now == '1) ? col_now : col_now + CW'(1);
    if (line_end && in_rows && (col_q != '0)) begin
      row_d = row_q + RW'(1);
      if (col_q < SHORT_C) err_short_d = 1'b1;
    end
    if (active && pix_in && in_rows && (col_now >= LONG_C)) err_long_d = 1'b1;

    if (pix_valid) begin
      r_d     = ccd_r;
      g_d     = ccd_g;
      b_d     = ccd_b;
      x_d     = XW'(row_q - BY_R);
      y_d     = YW'(col_now - BX_C);
      d_val_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = ARMED;
          stop_pend_d = 1'b0;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
        end
      end
      ARMED: begin
        if (stop) begin
          state_d = IDLE;
        end else if (fval_rise) begin
          state_d = ACTIVE;
          f_val_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ACTIVE: begin
        if (stop) stop_pend_d = 1'b1;
        if (fval_fall) begin
          fc_d        = fc_q + FW'(1);
          state_d     = (stop_pend_q || stop) ? IDLE : ARMED;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fval_prev_q <= 1'b0;
      lval_prev_q <= 1'b0;
      stop_pend_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      fc_q        <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      d_val_q     <= 1'b0;
      f_val_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fval_prev_q <= ccd_fval;
      lval_prev_q <= ccd_lval;
      stop_pend_q <= stop_pend_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fc_q        <= fc_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      x_q         <= x_d;
      y_q         <= y_d;
      d_val_q     <= d_val_d;
      f_val_q     <= f_val_d;
      busy_q      <= busy_d;
    end
  end

  assign red_out     = r_q;
  assign green_out   = g_q;
  assign blue_out    = b_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign d_val       = d_val_q;
  assign f_val       = f_val_q;
  assign frame_count = fc_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Scoreboard bench for ccd_frame_capture: expected pixels queued as stimulus is driven.
`timescale 1ns/1ps
module tb_ccd_frame_capture;
  localparam int NR = 32;
  localparam int NC = 32;
`ifdef CCD_BORDER_CROP_EN
  localparam int BX = 2;
  localparam int BY = 2;
`else
  localparam int BX = 0;
  localparam int BY = 0;
`endif
  localparam int FR = NR + 2 * BY;
  localparam int FC = NC + 2 * BX;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, ccd_fval, ccd_lval;
  logic [11:0] ccd_r, ccd_g, ccd_b;
  logic [11:0] red_out, green_out, blue_out;
  logic [4:0]  x_pos, y_pos;
  logic        d_val, f_val, err_short, err_long, busy;
  logic [7:0]  frame_count;

  typedef struct packed {
    logic [4:0]  x;
    logic [4:0]  y;
    logic [11:0] r;
    logic [11:0] g;
    logic [11:0] b;
  } pix_t;

  pix_t       exp_q[$];
  pix_t       mon_e, mon_got;
  int         errors = 0;
  int         checks = 0;
  int         dval_cnt = 0;
  int         fval_cnt = 0;
  int         line_len[64];
  logic [7:0] exp_fc = 8'd0;

  always #5 clk = ~clk;

  ccd_frame_capture dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .ccd_fval(ccd_fval), .ccd_lval(ccd_lval),
    .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .x_pos(x_pos), .y_pos(y_pos), .d_val(d_val), .f_val(f_val),
    .frame_count(frame_count), .err_short(err_short), .err_long(err_long), .busy(busy)
  );

  // Output monitor: every valid pixel must match the head of the scoreboard
  always @(negedge clk) begin
    if (f_val) fval_cnt++;
    if (d_val) begin
      dval_cnt++;
      checks++;
      mon_got = '{x: x_pos, y: y_pos, r: red_out, g: green_out, b: blue_out};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got x=%0d y=%0d, required no valid pixel", x_pos, y_pos);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_got !== mon_e) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d rgb=%h/%h/%h, required x=%0d y=%0d rgb=%h/%h/%h",
                   mon_got.x, mon_got.y, mon_got.r, mon_got.g, mon_got.b,
                   mon_e.x, mon_e.y, mon_e.r, mon_e.g, mon_e.b);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic drive_pixel(input int r, input int c, input bit cap);
    ccd_r = 12'($urandom);
    ccd_g = 12'($urandom);
    ccd_b = 12'($urandom);
    if (cap && r >= BY && r < BY + NR && c >= BX && c < BX + NC)
      exp_q.push_back('{x: 5'(r - BY), y: 5'(c - BX), r: ccd_r, g: ccd_g, b: ccd_b});
  endtask

  task automatic drive_frame(input bit cap, input bit pre_high, input int stop_row);
    if (!pre_high) begin
      ccd_fval = 1'b1;
      cyc(2);
    end
    for (int r = 0; r < FR; r++) begin
      ccd_lval = 1'b1;
      for (int c = 0; c < line_len[r]; c++) begin
        drive_pixel(r, c, cap);
        if (r == stop_row && c == 5) stop = 1'b1;
        cyc(1);
        stop = 1'b0;
      end
      ccd_lval = 1'b0;
      cyc(4);
    end
    ccd_fval = 1'b0;
    cyc(4);
  endtask

  task automatic clear_counts();
    dval_cnt = 0;
    fval_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; ccd_fval = 1'b0; ccd_lval = 1'b0;
    ccd_r = '0; ccd_g = '0; ccd_b = '0;
    for (int i = 0; i < 64; i++) line_len[i] = FC;
    cyc(3);
    checks++; if (d_val !== 1'b0 || f_val !== 1'b0) begin errors++; $display("FAIL reset_valids: got d_val=%b f_val=%b, required 0/0", d_val, f_val); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count: got %0d, required 0", frame_count); end
    checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b/%b, required 0/0", err_short, err_long); end
    checks++; if (x_pos !== 5'd0 || y_pos !== 5'd0 || red_out !== 12'd0) begin errors++; $display("FAIL reset_outputs: got x=%0d y=%0d r=%h, required 0", x_pos, y_pos, red_out); end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_basic_frame();
    clear_counts();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_armed: got %b, required 1", busy); end
    drive_frame(1'b1, 1'b0, -1);
    exp_fc = exp_fc + 8'd1;
    checks++; if (fval_cnt != 1) begin errors++; $display("FAIL basic_fval_pulses: got %0d, required 1", fval_cnt); end
    checks++; if (dval_cnt != NR * NC) begin errors++; $display("FAIL basic_dval_count: got %0d, required %0d", dval_cnt, NR * NC); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: got %0d pixels outstanding, required 0", exp_q.size()); end
    checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL basic_frame_count: got %0d, required %0d", frame_count, exp_fc); end
    checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin errors++; $display("FAIL basic_errs: got %b/%b, required 0/0", err_short, err_long); end
  endtask

  task automatic test_skip_in_progress();
    pulse_stop();
    cyc(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL skip_idle: got busy=%b, required 0", busy); end
    ccd_fval = 1'b1;
    cyc(3);
    pulse_start();
    clear_counts();
    drive_frame(1'b0, 1'b1, -1);
    checks++; if (dval_cnt != 0 || fval_cnt != 0) begin errors++; $display("FAIL skip_no_output: got d_val=%0d f_val=%0d, required 0/0", dval_cnt, fval_cnt); end
    checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL skip_frame_count: got %0d, required %0d", frame_count, exp_fc); end
    clear_counts();
    drive_frame(1'b1, 1'b0, -1);
    exp_fc = exp_fc + 8'd1;
    checks++; if (dval_cnt != NR * NC || fval_cnt != 1) begin errors++; $display("FAIL skip_next_frame: got d_val=%0d f_val=%0d, required %0d/1", dval_cnt, fval_cnt, NR * NC); end
    checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL skip_next_count: got %0d, required %0d", frame_count, exp_fc); end
  endtask

  task automatic test_line_errors();
    clear_counts();
    line_len[BY + 5] = BX + 30;
    drive_frame(1'b1, 1'b0, -1);
    exp_fc = exp_fc + 8'd1;
    checks++; if (err_short !== 1'b1 || err_long !== 1'b0) begin errors++; $display("FAIL short_flags: got short=%b long=%b, required 1/0", err_short, err_long); end
    checks++; if (dval_cnt != NR * NC - 2) begin errors++; $display("FAIL short_dval_count: got %0d, required %0d", dval_cnt, NR * NC - 2); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL short_missing: got %0d outstanding, required 0", exp_q.size()); end
    clear_counts();
    line_len[BY + 5] = FC;
    line_len[BY + 7] = FC + 2;
    drive_frame(1'b1, 1'b0, -1);
    exp_fc = exp_fc + 8'd1;
    line_len[BY + 7] = FC;
    checks++; if (err_long !== 1'b1) begin errors++; $display("FAIL long_flag: got %b, required 1", err_long); end
    checks++; if (dval_cnt != NR * NC) begin errors++; $display("FAIL long_dval_count: got %0d, required %0d", dval_cnt, NR * NC); end
    checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL err_frame_count: got %0d, required %0d", frame_count, exp_fc); end
  endtask

  task automatic test_back_to_back_stop();
    pulse_stop();
    pulse_start();
    cyc(1);
    checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin errors++; $display("FAIL start_clears_errs: got %b/%b, required 0/0", err_short, err_long); end
    clear_counts();
    drive_frame(1'b1, 1'b0, -1);
    drive_frame(1'b1, 1'b0, 10);
    exp_fc = exp_fc + 8'd2;
    checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL stop_frame_count: got %0d, required %0d", frame_count, exp_fc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b, required 0", busy); end
    checks++; if (dval_cnt != 2 * NR * NC || fval_cnt != 2) begin errors++; $display("FAIL stop_two_frames: got d_val=%0d f_val=%0d, required %0d/2", dval_cnt, fval_cnt, 2 * NR * NC); end
    clear_counts();
    drive_frame(1'b0, 1'b0, -1);
    checks++; if (dval_cnt != 0 || fval_cnt != 0) begin errors++; $display("FAIL stop_frame3: got d_val=%0d f_val=%0d, required 0/0", dval_cnt, fval_cnt); end
    checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL stop_frame3_count: got %0d, required %0d", frame_count, exp_fc); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    pulse_start();
    ccd_fval = 1'b1;
    cyc(2);
    for (int r = 0; r <= BY + 10; r++) begin
      ccd_lval = 1'b1;
      n = (r == BY + 10) ? BX + 11 : FC;
      for (int c = 0; c < n; c++) begin
        drive_pixel(r, c, 1'b1);
        if (r == BY + 10 && c == n - 1) begin
          @(posedge clk);
          #2;
        end else begin
          cyc(1);
        end
      end
      if (r < BY + 10) begin
        ccd_lval = 1'b0;
        cyc(4);
      end
    end
    checks++; if (d_val !== 1'b1 || x_pos !== 5'd10 || y_pos !== 5'd10) begin errors++; $display("FAIL pre_reset_pixel: got d_val=%b x=%0d y=%0d, required 1/10/10", d_val, x_pos, y_pos); end
    rst_n = 1'b0;
    #1;
    checks++; if (d_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got d_val=%b busy=%b, required 0/0", d_val, busy); end
    checks++; if (x_pos !== 5'd0 || y_pos !== 5'd0 || frame_count !== 8'd0) begin errors++; $display("FAIL async_reset_values: got x=%0d y=%0d fc=%0d, required 0/0/0", x_pos, y_pos, frame_count); end
    exp_q.delete();
    exp_fc = 8'd0;
    ccd_lval = 1'b0;
    ccd_fval = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    clear_counts();
    drive_frame(1'b0, 1'b0, -1);
    checks++; if (dval_cnt != 0 || fval_cnt != 0) begin errors++; $display("FAIL post_reset_output: got d_val=%0d f_val=%0d, required 0/0", dval_cnt, fval_cnt); end
    checks++; if (busy !== 1'b0 || frame_count !== exp_fc) begin errors++; $display("FAIL post_reset_state: got busy=%b fc=%0d, required 0/%0d", busy, frame_count, exp_fc); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_skip_in_progress();
    test_line_errors();
    test_back_to_back_stop();
    test_reset_mid_frame();
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccd_frame_capture.md
Name: ccd_frame_capture

Overview:
- Upstream stage of the greyscale converter. Turns raw sensor timing (level frame-valid, level line-valid, RGB pixels) into the stream that converter consumes: registered RGB, row/column position, one-cycle frame-start pulse and per-pixel data-valid.
- Sits between the camera interface and the greyscale block.
- Adds start/stop control, a frame counter and sticky line-length error flags.

Parameters:
- num_rows, 32, active image rows per frame
- num_cols, 32, active pixels per line
- full_frame_rows, 36, sensor rows including border (used only with crop)
- full_frame_cols, 36, sensor pixels per line including border (used only with crop)
- num_bits_rgb, 12, bits per colour channel
- frame_count_width, 8, width of frame counter

Ports:
- clk  in  1  pixel clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: arm capture
- stop  in  1  one-cycle pulse: stop after current frame completes
- ccd_fval  in  1  sensor frame valid (level)
- ccd_lval  in  1  sensor line valid (level)
- ccd_r, ccd_g, ccd_b  in  num_bits_rgb each  sensor pixel
- red_out, green_out, blue_out  out  num_bits_rgb each  registered pixel, valid with d_val
- x_pos  out  clog2(num_rows)  row index of current pixel
- y_pos  out  clog2(num_cols)  column index of current pixel
- d_val  out  1  pixel valid
- f_val  out  1  one-cycle frame-start pulse
- frame_count  out  frame_count_width  completed frames, wraps
- err_short  out  1  sticky: line ended with fewer than num_cols pixels
- err_long  out  1  sticky: line exceeded num_cols pixels
- busy  out  1  high in ARMED or ACTIVE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal counters 0; ccd_fval/ccd_lval edge registers cleared.
- Edge detection: ccd_fval and ccd_lval sampled once. rise = now & !prev; fall = !now & prev.
- FSM states:
  - IDLE: start -> ARMED.
  - ARMED: fval rise -> ACTIVE; f_val=1 for exactly that cycle's registered output (1 cycle after the edge sample); row=0. A frame already in progress at arm time is skipped (no rise seen).
  - ACTIVE: fval fall -> frame_count+1 (wraps), then ARMED, or IDLE if a stop is pending.
- stop: in ACTIVE, latched as stop_pending and the current frame finishes. In ARMED, goes to IDLE next cycle. start and stop in the same cycle: stop wins.
- Column/row counting:
  - Column counter clears on lval rise and increments per cycle while ccd_fval&ccd_lval.
  - Row counter increments on lval fall only if that line produced at least one valid pixel.
- Pixel valid (uncropped): in ACTIVE, fval&lval, col<num_cols, row<num_rows.
- Outputs: ccd_r/g/b, x_pos=row, y_pos=col and d_val registered together, 1-cycle latency. When d_val=0, x_pos/y_pos hold their last values and RGB is don't-care.
- Line-length errors:
  - Pixels beyond num_cols are dropped and set err_long.
  - lval fall with 0<col<num_cols sets err_short.
  - Both flags clear only on start or reset.
- Rows beyond num_rows are dropped silently.
- fval fall mid-line: the line is truncated and err_short is set if applicable.
- Reset mid-frame: outputs drop immediately. After release, the block needs start plus a fresh fval rise.

Optional Feature:
- Macro: CCD_BORDER_CROP_EN.
- Defined: leading bx=(full_frame_cols-num_cols)/2 pixels of each line and by=(full_frame_rows-num_rows)/2 lines of each frame are discarded before counting. y_pos=col-bx, x_pos=row-by. Length checks apply to the full_frame_cols window: err_short if the line is shorter than bx+num_cols; err_long if longer than full_frame_cols.
- Not defined: no cropping; counting starts at the first valid pixel. full_frame_* parameters are unused.

Test Plan:
- Reset, start, then one 32x32 frame (lval 32 cycles, 4-cycle gaps): f_val exactly one pulse; 1024 d_val cycles; x_pos/y_pos sweep 0..31 row-major; RGB equals input delayed 1 cycle; frame_count=1.
- fval already high when start issued: that frame produces no d_val or f_val; the next frame is captured fully.
- Line of 30 pixels at row 5: err_short=1; row 5 has 30 valid pixels; next line is x_pos=6. Line of 34 pixels: 32 valid pixels, err_long=1.
- stop issued mid-frame 2 of a continuous stream: frame 2 completes (frame_count=2); busy=0 after fval fall; frame 3 produces no output.
- rst_n low at pixel (10,10): outputs 0 asynchronously. After release with no start, a full frame produces no output.
- CCD_BORDER_CROP_EN with 36x36 sensor frame: first d_val at sensor row 2, col 2 with x_pos=0, y_pos=0; exactly 1024 valid pixels; no error flags.
